// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the two-port byte-memory arbiter.
// Build option: define ARB_ROUND_ROBIN_EN to make the arbiter alternate on ties.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        TAIL   = 2'd2,
        RESP   = 2'd3
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } owner_t;

    localparam int BEATS  = 4;
    localparam int BEAT_W = 2;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

endpackage

// File: rtl/mem_port_arbiter_arb_pick.sv
// Two-way request picker: load/store wins ties unless ARB_ROUND_ROBIN_EN is
// defined, in which case the port not granted last wins a tie.
module mem_port_arbiter_arb_pick
    import mem_port_arbiter_pkg::*;
(
    input  logic   if_req,
    input  logic   ls_req,
`ifdef ARB_ROUND_ROBIN_EN
    input  owner_t last_grant,
`endif
    output logic   gnt_if,
    output logic   gnt_ls
);

    // Produce a one-hot pick; a lone request always wins.
    always_comb begin
        gnt_if = 1'b0;
        gnt_ls = 1'b0;
        if (if_req && ls_req) begin
`ifdef ARB_ROUND_ROBIN_EN
            if (last_grant == OWN_LS) begin
                gnt_if = 1'b1;
            end else begin
                gnt_ls = 1'b1;
            end
`else
            gnt_ls = 1'b1;
`endif
        end else if (ls_req) begin
            gnt_ls = 1'b1;
        end else if (if_req) begin
            gnt_if = 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one byte-wide synchronous-read memory between instruction fetch and
// load/store; each 32-bit access is four little-endian byte beats.
// Build option: ARB_ROUND_ROBIN_EN selects round-robin tie breaking.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [31:0]   if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [31:0]   if_rdata,
    input  logic          ls_req,
    input  logic          ls_we,
    input  logic [31:0]   ls_addr,
    input  logic [31:0]   ls_wdata,
    output logic          ls_gnt,
    output logic          ls_rvalid,
    output logic [31:0]   ls_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [7:0]    mem_wdata,
    input  logic [7:0]    mem_rdata,
    output logic          busy
);

    state_t            state_q, state_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    owner_t            owner_q, owner_d;
    logic [AW-3:0]     addr_q, addr_d;
    logic              we_q, we_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [23:0]       word_q, word_d;
    logic [31:0]       if_rdata_q, if_rdata_d;
    logic [31:0]       ls_rdata_q, ls_rdata_d;
`ifdef ARB_ROUND_ROBIN_EN
    owner_t            last_q, last_d;
`endif

    logic pick_if, pick_ls;
    logic grant_if, grant_ls;
    logic idle;
    logic unused_addr_bits;

    // Word alignment and aliasing mean these address bits never reach memory.
    assign unused_addr_bits = ^{if_addr[31:AW], if_addr[1:0], ls_addr[31:AW], ls_addr[1:0]};

    mem_port_arbiter_arb_pick u_pick (
        .if_req     (if_req),
        .ls_req     (ls_req),
`ifdef ARB_ROUND_ROBIN_EN
        .last_grant (last_q),
`endif
        .gnt_if     (pick_if),
        .gnt_ls     (pick_ls)
    );

    assign idle     = (state_q == IDLE);
    assign grant_if = idle && !rst && pick_if;
    assign grant_ls = idle && !rst && pick_ls;

    // Next-state and datapath: grant in IDLE, stream beats, collect read bytes.
    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        owner_d    = owner_q;
        addr_d     = addr_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        word_d     = word_q;
        if_rdata_d = if_rdata_q;
        ls_rdata_d = ls_rdata_q;
`ifdef ARB_ROUND_ROBIN_EN
        last_d     = last_q;
`endif
        case (state_q)
            IDLE: begin
                if (grant_ls) begin
                    state_d = ACCESS;
                    beat_d  = '0;
                    owner_d = OWN_LS;
                    addr_d  = ls_addr[AW-1:2];
                    we_d    = ls_we;
                    wdata_d = ls_wdata;
`ifdef ARB_ROUND_ROBIN_EN
                    last_d  = OWN_LS;
`endif
                end else if (grant_if) begin
                    state_d = ACCESS;
                    beat_d  = '0;
                    owner_d = OWN_IF;
                    addr_d  = if_addr[AW-1:2];
                    we_d    = 1'b0;
                    wdata_d = '0;
`ifdef ARB_ROUND_ROBIN_EN
                    last_d  = OWN_IF;
`endif
                end
            end
            ACCESS: begin
                if (beat_q != '0 && !we_q) begin
                    word_d[{beat_q - BEAT_W'(1), 3'b000} +: 8] = mem_rdata;
                end
                if (beat_q == LAST_BEAT) begin
                    state_d = we_q ? RESP : TAIL;
                end else begin
                    beat_d = beat_q + BEAT_W'(1);
                end
            end
            TAIL: begin
                state_d = RESP;
                if (owner_q == OWN_IF) begin
                    if_rdata_d = {mem_rdata, word_q};
                end else begin
                    ls_rdata_d = {mem_rdata, word_q};
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Single register bank for FSM and datapath; reset drops any transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            beat_q     <= '0;
            owner_q    <= OWN_IF;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            word_q     <= '0;
            if_rdata_q <= '0;
            ls_rdata_q <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_q     <= OWN_IF;
`endif
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            owner_q    <= owner_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            word_q     <= word_d;
            if_rdata_q <= if_rdata_d;
            ls_rdata_q <= ls_rdata_d;
`ifdef ARB_ROUND_ROBIN_EN
            last_q     <= last_d;
`endif
        end
    end

    assign if_gnt    = grant_if;
    assign ls_gnt    = grant_ls;
    assign busy      = !idle;
    assign mem_en    = (state_q == ACCESS);
    assign mem_we    = mem_en && we_q;
    assign mem_addr  = mem_en ? {addr_q, beat_q} : '0;
    assign mem_wdata = mem_we ? wdata_q[{beat_q, 3'b000} +: 8] : '0;
    assign if_rvalid = (state_q == RESP) && (owner_q == OWN_IF);
    assign ls_rvalid = (state_q == RESP) && (owner_q == OWN_LS);
    assign if_rdata  = if_rdata_q;
    assign ls_rdata  = ls_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a byte memory, a word-level model and
// a monitor that checks beats, grants and responses.
// Honours ARB_ROUND_ROBIN_EN when predicting tie order.
module tb_mem_port_arbiter;

    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req;
    logic [31:0]   if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [31:0]   if_rdata;
    logic          ls_req;
    logic          ls_we;
    logic [31:0]   ls_addr;
    logic [31:0]   ls_wdata;
    logic          ls_gnt;
    logic          ls_rvalid;
    logic [31:0]   ls_rdata;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata;
    logic [7:0]    mem_rdata;
    logic          busy;

    mem_port_arbiter #(.AW(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .ls_req    (ls_req),
        .ls_we     (ls_we),
        .ls_addr   (ls_addr),
        .ls_wdata  (ls_wdata),
        .ls_gnt    (ls_gnt),
        .ls_rvalid (ls_rvalid),
        .ls_rdata  (ls_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Byte memory seen by the DUT: synchronous read, write on enable.
    logic [7:0] env_mem [0:1023];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) env_mem[mem_addr] <= mem_wdata;
            else        mem_rdata <= env_mem[mem_addr];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit          is_ls;
        bit          is_store;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_q[$];
    int          gnt_cyc_q[$];
    logic [7:0]  ref_mem [0:1023];
    bit          ref_last_ls;
    logic [31:0] ref_ls_rdata;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int word_base(input logic [31:0] a);
        return (int'(a % 32'd1024) / 4) * 4;
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        int b;
        b = word_base(a);
        return {ref_mem[b+3], ref_mem[b+2], ref_mem[b+1], ref_mem[b]};
    endfunction

    task automatic ref_write(input logic [31:0] a, input logic [31:0] d);
        int b;
        b = word_base(a);
        for (int i = 0; i < 4; i++) ref_mem[b+i] = d[8*i +: 8];
    endtask

    function automatic bit ref_pick_ls(input bit ifp, input bit lsp);
        if (ifp && lsp) begin
`ifdef ARB_ROUND_ROBIN_EN
            return !ref_last_ls;
`else
            return 1'b1;
`endif
        end
        return lsp;
    endfunction

    task automatic model_txn(input bit is_ls, input bit we, input logic [31:0] a, input logic [31:0] wd);
        exp_t e;
        e.is_ls    = is_ls;
        e.is_store = is_ls && we;
        if (e.is_store) begin
            ref_write(a, wd);
            e.data = ref_ls_rdata;
        end else begin
            e.data = ref_read(a);
            if (is_ls) ref_ls_rdata = e.data;
        end
        ref_last_ls = is_ls;
        exp_q.push_back(e);
    endtask

    task automatic model_reset();
        ref_last_ls  = 1'b0;
        ref_ls_rdata = '0;
        exp_q.delete();
    endtask

    function automatic logic [31:0] rand_addr();
        return ($urandom() & 32'hFFFF_FC00) | 32'($urandom_range(0, 47));
    endfunction

    // Monitor: beat bus contents, grant legality, response order/data/latency.
    bit          t_active = 1'b0;
    bit          t_store;
    int          t_cyc;
    logic [31:0] t_addr;
    logic [31:0] t_wdata;
    exp_t        m_e;
    int          m_g;
    int          m_d;
    int          m_k;

    always @(negedge clk) begin
        if (t_active) begin
            m_d = cyc - t_cyc;
            if (m_d >= 1 && m_d <= 4) begin
                m_k = m_d - 1;
                check_output("beat_en_we", {30'd0, mem_en, mem_we}, {30'd0, 1'b1, t_store});
                check_output("beat_addr", {22'd0, mem_addr}, 32'(word_base(t_addr) + m_k));
                if (t_store)
                    check_output("beat_wdata", {24'd0, mem_wdata}, (t_wdata >> (8 * m_k)) & 32'hFF);
            end else if (m_d == 5 && !t_store) begin
                check_output("tail_mem_en", {31'd0, mem_en}, 32'd0);
            end
            if (m_d >= 5) t_active = 1'b0;
        end
        if (if_gnt || ls_gnt) begin
            check_output("gnt_onehot_idle", {30'd0, (if_gnt && ls_gnt), busy}, 32'd0);
            gnt_cyc_q.push_back(cyc);
            t_active = 1'b1;
            t_cyc    = cyc;
            if (ls_gnt) begin
                t_addr  = ls_addr;
                t_store = ls_we;
                t_wdata = ls_wdata;
            end else begin
                t_addr  = if_addr;
                t_store = 1'b0;
                t_wdata = '0;
            end
        end
        if (if_rvalid || ls_rvalid) begin
            if (exp_q.size() == 0 || gnt_cyc_q.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected_rvalid: got if=%0b ls=%0b expected none (cycle %0d)",
                         if_rvalid, ls_rvalid, cyc);
            end else begin
                m_e = exp_q.pop_front();
                m_g = gnt_cyc_q.pop_front();
                check_output("rvalid_port", {30'd0, if_rvalid, ls_rvalid}, {30'd0, !m_e.is_ls, m_e.is_ls});
                check_output(m_e.is_ls ? "ls_rdata" : "if_rdata", m_e.is_ls ? ls_rdata : if_rdata, m_e.data);
                check_output("rvalid_latency", 32'(cyc - m_g), m_e.is_store ? 32'd5 : 32'd6);
            end
        end
        if (rst) begin
            t_active = 1'b0;
            gnt_cyc_q.delete();
        end
    end

    task automatic scramble_inputs();
        ls_addr  = $urandom();
        ls_wdata = $urandom();
        ls_we    = 1'($urandom_range(0, 1));
        if_addr  = $urandom();
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy) return;
        end
        total++;
        bad++;
        $display("[TB] FAIL idle_timeout: got busy=%0b pending=%0d expected idle", busy, exp_q.size());
        exp_q.delete();
    endtask

    task automatic apply_stimulus(input bit is_ls, input bit we, input logic [31:0] a, input logic [31:0] wd);
        bit got;
        got = 1'b0;
        model_txn(is_ls, we, a, wd);
        @(posedge clk); #1;
        if (is_ls) begin
            ls_req = 1'b1; ls_we = we; ls_addr = a; ls_wdata = wd;
        end else begin
            if_req = 1'b1; if_addr = a;
        end
        for (int n = 0; n < 30 && !got; n++) begin
            @(negedge clk);
            got = is_ls ? ls_gnt : if_gnt;
        end
        if (!got) begin
            total++; bad++;
            $display("[TB] FAIL gnt_timeout: got no gnt expected gnt on %s", is_ls ? "ls" : "if");
        end
        @(posedge clk); #1;
        ls_req = 1'b0;
        if_req = 1'b0;
        scramble_inputs();
        wait_idle();
    endtask

    task automatic do_overlap(input bit we, input logic [31:0] la, input logic [31:0] lwd, input logic [31:0] ia);
        bit got;
        int g;
        got = 1'b0;
        g   = 0;
        model_txn(1'b1, we, la, lwd);
        model_txn(1'b0, 1'b0, ia, 32'd0);
        @(posedge clk); #1;
        ls_req = 1'b1; ls_we = we; ls_addr = la; ls_wdata = lwd;
        for (int n = 0; n < 30 && !got; n++) begin
            @(negedge clk);
            if (ls_gnt) begin got = 1'b1; g = cyc; end
        end
        @(posedge clk); #1;
        ls_req = 1'b0;
        scramble_inputs();
        @(posedge clk); #1;
        if_req  = 1'b1;
        if_addr = ia;
        got = 1'b0;
        for (int n = 0; n < 30 && !got; n++) begin
            @(negedge clk);
            if (if_gnt) begin
                got = 1'b1;
                check_output("busy_hold_gnt_cycle", 32'(cyc - g), we ? 32'd6 : 32'd7);
            end
        end
        if (!got) begin
            total++; bad++;
            $display("[TB] FAIL overlap_gnt_timeout: got no if_gnt expected one");
        end
        @(posedge clk); #1;
        if_req = 1'b0;
        scramble_inputs();
        wait_idle();
    endtask

    task automatic do_tie(input int n, input bit once, input bit from_reset, input bit we,
                          input logic [31:0] la, input logic [31:0] lwd, input logic [31:0] ia);
        bit seq [0:7];
        bit ifp;
        bit lsp;
        bit p;
        bit saw_ls;
        int cnt;
        int prev;
        ifp  = 1'b1;
        lsp  = 1'b1;
        cnt  = 0;
        prev = 0;
        if (from_reset) begin
            @(posedge clk); #1;
            rst = 1'b1;
            ls_req = 1'b1; ls_we = we; ls_addr = la; ls_wdata = lwd;
            if_req = 1'b1; if_addr = ia;
            repeat (2) @(posedge clk);
            #1;
            model_reset();
        end
        for (int i = 0; i < n; i++) begin
            p = ref_pick_ls(ifp, lsp);
            seq[i] = p;
            model_txn(p, p && we, p ? la : ia, lwd);
            if (once) begin
                if (p) lsp = 1'b0;
                else   ifp = 1'b0;
            end
        end
        if (from_reset) begin
            rst = 1'b0;
        end else begin
            @(posedge clk); #1;
            ls_req = 1'b1; ls_we = we; ls_addr = la; ls_wdata = lwd;
            if_req = 1'b1; if_addr = ia;
        end
        for (int c = 0; c < 12 * n && cnt < n; c++) begin
            @(negedge clk);
            if (if_gnt || ls_gnt) begin
                saw_ls = ls_gnt;
                check_output("tie_order", {31'd0, saw_ls}, {31'd0, seq[cnt]});
                if (cnt > 0)
                    check_output("tie_gap", 32'(cyc - prev), (seq[cnt-1] && we) ? 32'd6 : 32'd7);
                prev = cyc;
                cnt++;
                if (once || cnt == n) begin
                    @(posedge clk); #1;
                    if (cnt == n) begin
                        ls_req = 1'b0; if_req = 1'b0;
                    end else if (saw_ls) begin
                        ls_req = 1'b0;
                    end else begin
                        if_req = 1'b0;
                    end
                end
            end
        end
        if (cnt < n) begin
            total++; bad++;
            $display("[TB] FAIL tie_timeout: got %0d grants expected %0d", cnt, n);
        end
        ls_req = 1'b0;
        if_req = 1'b0;
        scramble_inputs();
        wait_idle();
    endtask

    task automatic do_midreset(input logic [31:0] a);
        bit got;
        got = 1'b0;
        @(posedge clk); #1;
        if_req  = 1'b1;
        if_addr = a;
        for (int n = 0; n < 30 && !got; n++) begin
            @(negedge clk);
            got = if_gnt;
        end
        if (!got) begin
            total++; bad++;
            $display("[TB] FAIL midreset_gnt_timeout: got no if_gnt expected one");
        end
        @(posedge clk); #1;
        if_req = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        check_output("reset_busy", {31'd0, busy}, 32'd0);
        check_output("reset_mem_en", {31'd0, mem_en}, 32'd0);
        repeat (10) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] a1, a2, wd;
        int r;
        for (int i = 0; i < 1024; i++) begin
            env_mem[i] = 8'($urandom());
            ref_mem[i] = env_mem[i];
        end
        rst = 1'b1;
        if_req = 1'b0; if_addr = '0;
        ls_req = 1'b0; ls_we = 1'b0; ls_addr = '0; ls_wdata = '0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_output("reset_flags", {21'd0, if_gnt, if_rvalid, ls_gnt, ls_rvalid, mem_en, mem_we, busy, mem_wdata} , 32'd0);
        check_output("reset_mem_addr", {22'd0, mem_addr}, 32'd0);
        check_output("reset_if_rdata", if_rdata, 32'd0);
        check_output("reset_ls_rdata", ls_rdata, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        apply_stimulus(1'b1, 1'b1, 32'h008, 32'hDEADBEEF);
        check_output("store_bytes", {env_mem[11], env_mem[10], env_mem[9], env_mem[8]}, 32'hDEADBEEF);
        apply_stimulus(1'b0, 1'b0, 32'h008, 32'd0);
        apply_stimulus(1'b0, 1'b0, 32'hFFFF_FC09, 32'd0);
        apply_stimulus(1'b1, 1'b1, 32'h010, 32'h12345678);
        apply_stimulus(1'b1, 1'b0, 32'h010, 32'd0);
        apply_stimulus(1'b1, 1'b1, 32'h014, 32'hCAFEF00D);
        check_output("store_keeps_ls_rdata", ls_rdata, 32'h12345678);
        apply_stimulus(1'b1, 1'b0, 32'h403, 32'd0);
        do_overlap(1'b0, 32'h020, 32'd0, 32'h010);
        do_tie(2, 1'b1, 1'b1, 1'b0, 32'h014, 32'd0, 32'h008);
        do_tie(3, 1'b0, 1'b0, 1'b0, 32'h010, 32'd0, 32'h014);
        do_midreset(32'h008);
        apply_stimulus(1'b0, 1'b0, 32'h014, 32'd0);

        for (int i = 0; i < 40; i++) begin
            r  = $urandom_range(0, 9);
            a1 = rand_addr();
            a2 = rand_addr();
            wd = $urandom();
            if (r < 6)
                apply_stimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a1, wd);
            else if (r < 8)
                do_overlap(1'($urandom_range(0, 1)), a1, wd, a2);
            else if ($urandom_range(0, 1) == 0)
                do_tie(2, 1'b1, 1'b0, 1'($urandom_range(0, 1)), a1, wd, a2);
            else
                do_tie($urandom_range(2, 4), 1'b0, 1'b0, 1'($urandom_range(0, 1)), a1, wd, a2);
        end

        repeat (3) @(negedge clk);
        check_output("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
